// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: COREFIFO read-side and output-stream bundle.
// master = arbiter side, slave = FIFOs plus downstream consumer.
interface fifo_rd_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        FIFO_EMPTY;
  logic [NUM_CH*DWIDTH-1:0] FIFO_Q;
  logic [NUM_CH-1:0]        FIFO_RE;
  logic [DWIDTH-1:0]        OUT_DATA;
  logic [CW-1:0]            OUT_CH;
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic                     BUSY;

  modport master (
    input  FIFO_EMPTY, FIFO_Q, OUT_READY,
    output FIFO_RE, OUT_DATA, OUT_CH,
    output OUT_VALID, BUSY
  );

  modport slave (
    output FIFO_EMPTY, FIFO_Q, OUT_READY,
    input  FIFO_RE, OUT_DATA, OUT_CH,
    input  OUT_VALID, BUSY
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst reader over NUM_CH COREFIFOs.
// Optional word counter: define FIFO_RD_ARBITER_STATS_EN.
module fifo_rd_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DWIDTH    = 4,
  parameter int BURST_LEN = 8
) (
  input  logic CLK,
  input  logic RESET,
`ifdef FIFO_RD_ARBITER_STATS_EN
  input  logic        STAT_CLR,
  output logic [15:0] WORD_CNT,
`endif
  fifo_rd_arbiter_if.master bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_grant;
  logic [CW-1:0]     r_last_grant;
  logic [CW-1:0]     r_if_ch;
  logic [CW-1:0]     w_sel;
  logic              w_found;
  logic [BW-1:0]     r_burst_cnt;
  logic              r_inflight;
  logic [1:0]        r_buf_cnt;
  logic [DWIDTH-1:0] r_buf_data [2];
  logic [CW-1:0]     r_buf_ch [2];
  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic              w_re_any;
  logic              w_gempty;
  logic [NUM_CH-1:0] w_re;
  logic [2:0]        w_occ;
  logic [DWIDTH-1:0] w_q;

  function automatic logic [CW-1:0] f_wrap(
    input logic [CW-1:0] b,
    input int            k
  );
    int s;
    s = int'(b) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  assign w_pop    = bus.OUT_VALID & bus.OUT_READY;
  assign w_push   = r_inflight;
  assign w_gempty = bus.FIFO_EMPTY[r_grant];
  assign w_occ    = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
  // a new RE must still fit once the in-flight word lands
  assign w_room   = w_occ < (3'd2 + {2'b00, w_pop});

  // first non-empty channel after last_grant; lowest k wins
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last_grant;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (!bus.FIFO_EMPTY[f_wrap(r_last_grant, k)]) begin
        w_found = 1'b1;
        w_sel   = f_wrap(r_last_grant, k);
      end
    end
  end

  // mux the Q of the channel whose word is landing
  always_comb begin
    w_q = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_if_ch == CW'(i)) w_q = bus.FIFO_Q[i*DWIDTH +: DWIDTH];
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state and read enable
  always_comb begin
    w_state_nxt = r_state;
    w_re        = '0;
    w_re_any    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        w_re_any = !w_gempty && w_room && !RESET;
        if (w_re_any) begin
          w_re[r_grant] = 1'b1;
          if (r_burst_cnt == BW'(BURST_LEN - 1))
            w_state_nxt = S_IDLE;
        end else if (w_gempty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // grant, burst count and in-flight tracking
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_grant      <= '0;
      r_last_grant <= CW'(NUM_CH - 1);
      r_burst_cnt  <= '0;
      r_inflight   <= 1'b0;
      r_if_ch      <= '0;
    end else begin
      r_inflight <= w_re_any;
      if (w_re_any) r_if_ch <= r_grant;
      if (r_state == S_IDLE && w_found) begin
        r_grant     <= w_sel;
        r_burst_cnt <= '0;
      end else if (w_re_any) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      if (r_state == S_BURST && w_state_nxt == S_IDLE)
        r_last_grant <= r_grant;
    end
  end

  // two-entry output buffer, head at index 0
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_buf_cnt     <= '0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_ch[0]   <= '0;
      r_buf_ch[1]   <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          r_buf_data[r_buf_cnt[0]] <= w_q;
          r_buf_ch[r_buf_cnt[0]]   <= r_if_ch;
          r_buf_cnt                <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf_data[0] <= r_buf_data[1];
          r_buf_ch[0]   <= r_buf_ch[1];
          r_buf_cnt     <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf_data[0] <= w_q;
            r_buf_ch[0]   <= r_if_ch;
          end else begin
            r_buf_data[0] <= r_buf_data[1];
            r_buf_ch[0]   <= r_buf_ch[1];
            r_buf_data[1] <= w_q;
            r_buf_ch[1]   <= r_if_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.FIFO_RE   = w_re;
  assign bus.OUT_DATA  = r_buf_data[0];
  assign bus.OUT_CH    = r_buf_ch[0];
  assign bus.OUT_VALID = (r_buf_cnt != 2'd0);
  assign bus.BUSY      = (r_state == S_BURST) | r_inflight
                       | (r_buf_cnt != 2'd0);

`ifdef FIFO_RD_ARBITER_STATS_EN
  logic [15:0] r_word_cnt;

  // saturating count of accepted words; clear has priority
  always_ff @(posedge CLK) begin
    if (RESET || STAT_CLR)
      r_word_cnt <= '0;
    else if (w_pop && r_word_cnt != 16'hFFFF)
      r_word_cnt <= r_word_cnt + 16'd1;
  end

  assign WORD_CNT = r_word_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: vector table plus COREFIFO-model sequences.
// Stats checks compile in with FIFO_RD_ARBITER_STATS_EN.
module tb_fifo_rd_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int BL  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.NUM_CH(NCH), .DWIDTH(DW)) bus ();

`ifdef FIFO_RD_ARBITER_STATS_EN
  logic        stat_clr;
  logic [15:0] word_cnt;
`endif

  fifo_rd_arbiter #(
    .NUM_CH(NCH), .DWIDTH(DW), .BURST_LEN(BL)
  ) dut (
    .CLK(clk),
    .RESET(rst),
`ifdef FIFO_RD_ARBITER_STATS_EN
    .STAT_CLR(stat_clr),
    .WORD_CNT(word_cnt),
`endif
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  empty;
    logic [47:0] q;
    logic        rdy;
    logic [3:0]  re;
    logic        valid;
    logic [1:0]  ch;
    logic [11:0] data;
    logic        busy;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [NCH][$];
  logic [DW-1:0] fq [NCH];
  logic [NCH-1:0] last_re;
  logic           rdy;
  logic           refill;
  logic [DW-1:0]  rx_d [$];
  logic [1:0]     rx_c [$];
  int             re_cyc [$];
  int             cyc_n;
  int             re_cnt;
  int             onehot_bad;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] e, input logic [47:0] q, input logic r,
    input logic [3:0] re, input logic v, input logic [1:0] c,
    input logic [11:0] d, input logic b);
    vec_t t;
    t.empty = e; t.q = q; t.rdy = r; t.re = re;
    t.valid = v; t.ch = c; t.data = d; t.busy = b;
    return t;
  endfunction

  function automatic logic [DW-1:0] wd(input int c, input int k);
    return DW'(c * 256 + (k % 256));
  endfunction

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) mem[c].push_back(wd(c, k));
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCH; i++) begin
      mem[i].delete();
      fq[i] = '0;
    end
    last_re = '0;
    rx_d.delete();
    rx_c.delete();
    re_cyc.delete();
    re_cnt = 0;
    onehot_bad = 0;
    refill = 1'b0;
  endtask

  task automatic settle();
    logic [NCH*DW-1:0] qv;
    logic [NCH-1:0]    ev;
    for (int i = 0; i < NCH; i++) begin
      if (last_re[i] && mem[i].size() > 0)
        fq[i] = mem[i].pop_front();
      if (refill && mem[i].size() < 4) load(i, 8);
      ev[i] = (mem[i].size() == 0);
      qv[i*DW +: DW] = fq[i];
    end
    bus.FIFO_EMPTY = ev;
    bus.FIFO_Q     = qv;
    bus.OUT_READY  = rdy;
    #1;
  endtask

  task automatic tally();
    last_re = bus.FIFO_RE;
    if ($countones(bus.FIFO_RE) > 1) onehot_bad++;
    if (bus.FIFO_RE != '0) begin
      re_cnt++;
      re_cyc.push_back(cyc_n);
    end
    if (bus.OUT_VALID && rdy) begin
      rx_d.push_back(bus.OUT_DATA);
      rx_c.push_back(bus.OUT_CH);
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    tally();
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = 0;
    while ((rx_d.size() < n || bus.BUSY) && b < budget) begin
      step();
      b++;
    end
  endtask

  task automatic do_reset();
    clear_model();
    rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t tv [17];

  initial begin
    int nxt [NCH];
    int bad;
    int idx;
    logic held;
    logic [DW-1:0] hd;
    logic [1:0]    hc;
    logic [DW-1:0] snap;

    tv[0]  = mk(4'hF, 48'h0, 1, 4'h0, 0, 0, 12'h0, 0);
    tv[1]  = mk(4'hE, 48'h0, 1, 4'h0, 0, 0, 12'h0, 0);
    tv[2]  = mk(4'hE, 48'h0, 1, 4'h1, 0, 0, 12'h0, 1);
    tv[3]  = mk(4'hE, 48'hA01, 1, 4'h1, 0, 0, 12'h0, 1);
    tv[4]  = mk(4'hF, 48'hA02, 1, 4'h0, 1, 0, 12'hA01, 1);
    tv[5]  = mk(4'hF, 48'hA02, 0, 4'h0, 1, 0, 12'hA02, 1);
    tv[6]  = mk(4'hF, 48'hA02, 0, 4'h0, 1, 0, 12'hA02, 1);
    tv[7]  = mk(4'hF, 48'hA02, 1, 4'h0, 1, 0, 12'hA02, 1);
    tv[8]  = mk(4'hF, 48'h0, 1, 4'h0, 0, 0, 12'h0, 0);
    tv[9]  = mk(4'h5, 48'h0, 1, 4'h0, 0, 0, 12'h0, 0);
    tv[10] = mk(4'h5, 48'h0, 1, 4'h2, 0, 0, 12'h0, 1);
    tv[11] = mk(4'h7, 48'hB01000, 1, 4'h0, 0, 0, 12'h0, 1);
    tv[12] = mk(4'h7, 48'hB01000, 1, 4'h0, 1, 1, 12'hB01, 1);
    tv[13] = mk(4'h7, 48'h0, 1, 4'h8, 0, 0, 12'h0, 1);
    tv[14] = mk(4'hF, 48'hD01000000000, 1, 4'h0, 0, 0, 12'h0, 1);
    tv[15] = mk(4'hF, 48'hD01000000000, 1, 4'h0, 1, 3, 12'hD01, 1);
    tv[16] = mk(4'hF, 48'h0, 1, 4'h0, 0, 0, 12'h0, 0);

    cyc_n = 0;
`ifdef FIFO_RD_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif
    // reset state
    do_reset();
    settle();
    chk("rst re", bus.FIFO_RE, 0);
    chk("rst valid", bus.OUT_VALID, 0);
    chk("rst busy", bus.BUSY, 0);
    chk("rst data", bus.OUT_DATA, 0);
    chk("rst ch", bus.OUT_CH, 0);

    // directly driven per-cycle vectors
    for (int i = 0; i < 17; i++) begin
      bus.FIFO_EMPTY = tv[i].empty;
      bus.FIFO_Q     = tv[i].q;
      bus.OUT_READY  = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d re", i), bus.FIFO_RE, tv[i].re);
      chk($sformatf("vec%0d valid", i), bus.OUT_VALID, tv[i].valid);
      chk($sformatf("vec%0d busy", i), bus.BUSY, tv[i].busy);
      if (tv[i].valid) begin
        chk($sformatf("vec%0d data", i), bus.OUT_DATA, tv[i].data);
        chk($sformatf("vec%0d ch", i), bus.OUT_CH, tv[i].ch);
      end
      @(posedge clk);
      #1;
    end

    // three words on ch0
    do_reset();
    load(0, 3);
    run_until(3, 40);
    chk("c28 words", rx_d.size(), 3);
    chk("c28 re", re_cnt, 3);
    if (re_cyc.size() == 3)
      chk("c28 re span", re_cyc[2] - re_cyc[0], 2);
    bad = 0;
    foreach (rx_d[i])
      if (rx_d[i] !== wd(0, i) || rx_c[i] !== 2'd0) bad++;
    chk("c28 order", bad, 0);
    chk("c28 idle", bus.BUSY, 0);

    // two channels, bursts of BL
    do_reset();
    load(0, 20);
    load(2, 20);
    run_until(40, 200);
    chk("c29 words", rx_d.size(), 40);
    bad = 0;
    idx = 0;
    nxt = '{default: 0};
    foreach (rx_d[i]) begin
      int c;
      int blk;
      blk = (i < 32) ? i / 8 : (i - 32) / 4;
      c = (blk % 2 == 0) ? 0 : 2;
      if (rx_c[i] !== 2'(c) || rx_d[i] !== wd(c, nxt[c])) bad++;
      nxt[c]++;
    end
    chk("c29 sequence", bad, 0);
    if (re_cyc.size() >= 32)
      chk("c29 gaps", re_cyc[31] - re_cyc[0], 34);

    // downstream stall on ch1
    do_reset();
    load(1, 10);
    rdy = 1'b0;
    snap = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 5) snap = bus.OUT_DATA;
    end
    chk("c30 stall re", re_cnt, 2);
    chk("c30 stall valid", bus.OUT_VALID, 1);
    chk("c30 stall snap", snap, wd(1, 0));
    chk("c30 stall hold", bus.OUT_DATA, wd(1, 0));
    chk("c30 busy", bus.BUSY, 1);
    rdy = 1'b1;
    run_until(10, 60);
    chk("c30 words", rx_d.size(), 10);
    bad = 0;
    foreach (rx_d[i])
      if (rx_d[i] !== wd(1, i) || rx_c[i] !== 2'd1) bad++;
    chk("c30 order", bad, 0);

    // reset with one word buffered and one in flight
    do_reset();
    load(2, 5);
    rdy = 1'b0;
    step();
    step();
    step();
    chk("c31 pre re", re_cnt, 2);
    chk("c31 pre valid", bus.OUT_VALID, 1);
    load(0, 3);
    load(3, 3);
    rdy = 1'b1;
    rst = 1'b1;
    settle();
    chk("c31 rst re", bus.FIFO_RE, 0);
    tally();
    rst = 1'b0;
    rx_d.delete();
    rx_c.delete();
    settle();
    chk("c31 post valid", bus.OUT_VALID, 0);
    chk("c31 post re", bus.FIFO_RE, 0);
    chk("c31 post busy", bus.BUSY, 0);
    tally();
    settle();
    chk("c31 first re", bus.FIFO_RE, 4'b0001);
    tally();
    run_until(1, 20);
    if (rx_c.size() > 0) begin
      chk("c31 first ch", rx_c[0], 0);
      chk("c31 first data", rx_d[0], wd(0, 0));
    end else begin
      chk("c31 first word", rx_c.size(), 1);
    end

    // random back-pressure, all channels full
    do_reset();
    for (int c = 0; c < NCH; c++) load(c, 64);
    held = 1'b0;
    hd = '0;
    hc = '0;
    bad = 0;
    for (int i = 0; i < 4000 && rx_d.size() < 256; i++) begin
      rdy = 1'($urandom_range(0, 1));
      settle();
      if (held && (bus.OUT_DATA !== hd || bus.OUT_CH !== hc ||
                   !bus.OUT_VALID)) bad++;
      held = bus.OUT_VALID && !rdy;
      hd = bus.OUT_DATA;
      hc = bus.OUT_CH;
      tally();
    end
    chk("c32 words", rx_d.size(), 256);
    chk("c32 onehot", onehot_bad, 0);
    chk("c32 hold", bad, 0);
    nxt = '{default: 0};
    bad = 0;
    foreach (rx_d[i]) begin
      if (rx_d[i] !== wd(int'(rx_c[i]), nxt[rx_c[i]])) bad++;
      nxt[rx_c[i]]++;
    end
    chk("c32 order", bad, 0);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("c32 ch%0d count", c), nxt[c], 64);

`ifdef FIFO_RD_ARBITER_STATS_EN
    // counter saturation and clear
    do_reset();
    chk("st reset", word_cnt, 0);
    refill = 1'b1;
    for (int i = 0; i < 75000; i++) begin
      step();
      rx_d.delete();
      rx_c.delete();
    end
    chk("st sat", word_cnt, 16'hFFFF);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("st clr", word_cnt, 0);
    refill = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
